// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the serial-bit sequence
// detector. A WIDTH-bit word is accepted over a valid/ready handshake and
// shifted out one bit per clock on ser_out. The line then holds IDLE_BIT for
// GAP_CYCLES clocks and spends one IDLE clock before the next word can be
// accepted.
//
// Optional feature: define SER_PARITY_EN to append one even-parity bit
// (PAR state) after the data bits. frame_done then marks the parity bit
// instead of the last data bit.
module bit_serializer #(
   parameter int   WIDTH      = 8,     // bits per word, >= 2
   parameter int   MSB_FIRST  = 1,     // 1: bit WIDTH-1 first, 0: bit 0 first
   parameter int   GAP_CYCLES = 2,     // idle clocks after each frame, 0..255
   parameter logic IDLE_BIT   = 1'b0   // ser_out level while ser_valid=0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_done,
   output logic             busy
);

   localparam int             CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH);
   localparam logic [CW-1:0]  LAST_M1  = CW'(WIDTH - 1);
   localparam logic [7:0]     GAP_LOAD = 8'(GAP_CYCLES);

`ifdef SER_PARITY_EN
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR, S_GAP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
`endif

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;        // data bits already placed on ser_out
   logic [WIDTH-1:0] sreg_q, sreg_d;      // remaining bits, next one at the head
   logic [7:0]       gap_q, gap_d;        // gap clocks still to spend
   logic             ser_out_d, ser_valid_d, frame_done_d;
`ifdef SER_PARITY_EN
   logic             par_q, par_d;        // even parity of the captured word
`endif

   // Bit that leaves the word first in the configured order.
   function automatic logic head_bit(input logic [WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
   endfunction

   // Word with its head bit removed, next bit moved to the head.
   function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
   endfunction

   // State that follows the final bit of a frame.
   function automatic state_t after_frame();
      return (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
   endfunction

   // Next-state and next-output logic for the registered outputs.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      cnt_d        = cnt_q;
      sreg_d       = sreg_q;
      gap_d        = gap_q;
      ser_out_d    = IDLE_BIT;
      ser_valid_d  = 1'b0;
      frame_done_d = 1'b0;
`ifdef SER_PARITY_EN
      par_d        = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            // load_ready is high only here, so load_valid alone marks an accept.
            if (load_valid) begin
               state_d     = S_SHIFT;
               ser_out_d   = head_bit(data_in);
               ser_valid_d = 1'b1;
               sreg_d      = drop_head(data_in);
               cnt_d       = CW'(1);
`ifdef SER_PARITY_EN
               par_d       = ^data_in;
`endif
            end
         end
         S_SHIFT: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d = '0;
`ifdef SER_PARITY_EN
               state_d      = S_PAR;
               ser_out_d    = par_q;
               ser_valid_d  = 1'b1;
               frame_done_d = 1'b1;
`else
               state_d = after_frame();
               gap_d   = GAP_LOAD;
`endif
            end else begin
               ser_out_d   = head_bit(sreg_q);
               ser_valid_d = 1'b1;
               sreg_d      = drop_head(sreg_q);
               cnt_d       = cnt_q + CW'(1);
`ifndef SER_PARITY_EN
               frame_done_d = (cnt_q == LAST_M1);
`endif
            end
         end
`ifdef SER_PARITY_EN
         S_PAR: begin
            state_d = after_frame();
            gap_d   = GAP_LOAD;
         end
`endif
         S_GAP: begin
            if (gap_q <= 8'd1) begin
               state_d = S_IDLE;
               gap_d   = '0;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset aborts any frame in progress.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         // NOTE: the shift register is explicitly cleared so a word cut off by
         // reset can never leak into a later frame.
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         sreg_q     <= '0;
         gap_q      <= '0;
         ser_out    <= IDLE_BIT;
         ser_valid  <= 1'b0;
         frame_done <= 1'b0;
`ifdef SER_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sreg_q     <= sreg_d;
         gap_q      <= gap_d;
         ser_out    <= ser_out_d;
         ser_valid  <= ser_valid_d;
         frame_done <= frame_done_d;
`ifdef SER_PARITY_EN
         par_q      <= par_d;
`endif
      end
   end

   assign load_ready = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer. Two instances: dut_a (MSB first, gap 2) and
// dut_b (LSB first, gap 0). A frame-level reference model predicts every
// clock of both outputs; directed tasks add explicit boundary checks.
module tb_bit_serializer;

   localparam int W     = 8;
`ifdef SER_PARITY_EN
   localparam int PB    = 1;
`else
   localparam int PB    = 0;
`endif
   localparam int GAP_A = 2;
   localparam int GAP_B = 0;
   localparam int PER_A = W + PB + GAP_A + 1;
   localparam int PER_B = W + PB + GAP_B + 1;

   typedef struct packed {logic so; logic sv; logic fd; logic rdy;} exp_t;
   typedef exp_t exp_q_t[$];
   localparam exp_t IDLE_E = '{so: 1'b0, sv: 1'b0, fd: 1'b0, rdy: 1'b1};

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         lv_a = 1'b0, lv_b = 1'b0;
   logic [W-1:0] din_a = '0, din_b = '0;
   logic         lr_a, so_a, sv_a, fd_a, busy_a;
   logic         lr_b, so_b, sv_b, fd_b, busy_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1), .GAP_CYCLES(GAP_A), .IDLE_BIT(1'b0)) dut_a (
      .clk(clk), .rst(rst), .data_in(din_a), .load_valid(lv_a), .load_ready(lr_a),
      .ser_out(so_a), .ser_valid(sv_a), .frame_done(fd_a), .busy(busy_a));

   bit_serializer #(.WIDTH(W), .MSB_FIRST(0), .GAP_CYCLES(GAP_B), .IDLE_BIT(1'b0)) dut_b (
      .clk(clk), .rst(rst), .data_in(din_b), .load_valid(lv_b), .load_ready(lr_b),
      .ser_out(so_b), .ser_valid(sv_b), .frame_done(fd_b), .busy(busy_b));

   // Expected clock-by-clock output sequence of one frame after its accept.
   function automatic exp_q_t make_frame(input logic [W-1:0] w, input bit msb, input int gap);
      exp_q_t q;
      q = {};
      for (int i = 0; i < W; i++) begin
         exp_t e;
         e.so  = msb ? w[W-1-i] : w[i];
         e.sv  = 1'b1;
         e.fd  = (i == W - 1) && (PB == 0);
         e.rdy = 1'b0;
         q.push_back(e);
      end
      if (PB != 0) q.push_back('{so: ^w, sv: 1'b1, fd: 1'b1, rdy: 1'b0});
      for (int g = 0; g < gap; g++) q.push_back('{so: 1'b0, sv: 1'b0, fd: 1'b0, rdy: 1'b0});
      return q;
   endfunction

   // Reference model: the pending frame queue and the current expected cycle.
   exp_q_t q_a, q_b;
   exp_t   ea = IDLE_E;
   exp_t   eb = IDLE_E;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q_a = {}; q_b = {}; ea = IDLE_E; eb = IDLE_E;
      end else begin
         if (lv_a && ea.rdy) q_a = make_frame(din_a, 1'b1, GAP_A);
         if (lv_b && eb.rdy) q_b = make_frame(din_b, 1'b0, GAP_B);
         ea = (q_a.size() > 0) ? q_a.pop_front() : IDLE_E;
         eb = (q_b.size() > 0) ? q_b.pop_front() : IDLE_E;
      end
   end

   // Scoreboard: every falling edge compares both instances with the model.
   always @(negedge clk) begin
      exp_t act;
      act = '{so: so_a, sv: sv_a, fd: fd_a, rdy: lr_a};
      total++;
      if (act !== ea || busy_a !== ~ea.rdy) begin
         bad++;
         $display("FAIL sb_a t=%0t got so/sv/fd/rdy/busy=%b%b%b%b%b want %b%b%b%b%b", $time,
                  so_a, sv_a, fd_a, lr_a, busy_a, ea.so, ea.sv, ea.fd, ea.rdy, ~ea.rdy);
      end
      act = '{so: so_b, sv: sv_b, fd: fd_b, rdy: lr_b};
      total++;
      if (act !== eb || busy_b !== ~eb.rdy) begin
         bad++;
         $display("FAIL sb_b t=%0t got so/sv/fd/rdy/busy=%b%b%b%b%b want %b%b%b%b%b", $time,
                  so_b, sv_b, fd_b, lr_b, busy_b, eb.so, eb.sv, eb.fd, eb.rdy, ~eb.rdy);
      end
   end

   // Reassembles dut_a's serial data bits into words; counts frame_done pulses.
   logic [W-1:0] rx_a[$];
   logic [W-1:0] sh_a = '0;
   int           nb_a = 0;
   int           fdc_a = 0;
   always @(negedge clk) begin
      if (rst || !sv_a) begin
         nb_a = 0;
      end else begin
         if (nb_a < W) sh_a = {sh_a[W-2:0], so_a};
         nb_a++;
         if (nb_a == W) rx_a.push_back(sh_a);
      end
      if (fd_a === 1'b1) fdc_a++;
   end

   task automatic idle_cycles(input int n);
      lv_a = 1'b0; lv_b = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total += 5;
      if (so_a !== 1'b0 || so_b !== 1'b0) begin bad++; $display("FAIL rst_ser_out got %b%b want 00", so_a, so_b); end
      if (sv_a !== 1'b0 || sv_b !== 1'b0) begin bad++; $display("FAIL rst_ser_valid got %b%b want 00", sv_a, sv_b); end
      if (fd_a !== 1'b0 || fd_b !== 1'b0) begin bad++; $display("FAIL rst_frame_done got %b%b want 00", fd_a, fd_b); end
      if (lr_a !== 1'b1 || lr_b !== 1'b1) begin bad++; $display("FAIL rst_load_ready got %b%b want 11", lr_a, lr_b); end
      if (busy_a !== 1'b0 || busy_b !== 1'b0) begin bad++; $display("FAIL rst_busy got %b%b want 00", busy_a, busy_b); end
      @(posedge clk); #1 rst = 1'b0;
      idle_cycles(2);
   endtask

   // 0xB4 MSB first: bits, frame_done position, gap and return of ready.
   task automatic test_msb_frame();
      logic [W-1:0] w;
      int n;
      w = 8'hB4;
      n = W + PB + GAP_A + 1;
      din_a = w; lv_a = 1'b1;
      @(posedge clk); #1;
      lv_a = 1'b0; din_a = W'($urandom);
      for (int k = 1; k <= n; k++) begin
         logic eso, esv, efd, erdy;
         @(negedge clk);
         if (k <= W) begin eso = w[W-k]; esv = 1'b1; end
         else if (k == W + 1 && PB != 0) begin eso = ^w; esv = 1'b1; end
         else begin eso = 1'b0; esv = 1'b0; end
         efd  = (k == W + PB);
         erdy = (k == n);
         total++;
         if ({so_a, sv_a, fd_a, lr_a} !== {eso, esv, efd, erdy}) begin
            bad++;
            $display("FAIL msb_frame cycle %0d got so/sv/fd/rdy=%b%b%b%b want %b%b%b%b",
                     k, so_a, sv_a, fd_a, lr_a, eso, esv, efd, erdy);
         end
      end
      idle_cycles(2);
   endtask

   // 0x01 LSB first on dut_b: the set bit leads the frame.
   task automatic test_lsb_first();
      logic [W-1:0] w;
      w = 8'h01;
      din_b = w; lv_b = 1'b1;
      @(posedge clk); #1;
      lv_b = 1'b0;
      for (int k = 1; k <= W; k++) begin
         @(negedge clk);
         total++;
         if (so_b !== w[k-1] || sv_b !== 1'b1) begin
            bad++;
            $display("FAIL lsb_first bit %0d got so/sv=%b%b want %b1", k, so_b, sv_b, w[k-1]);
         end
      end
      idle_cycles(4);
   endtask

   // Gap of zero: 0xFF then 0x00 with load_valid held; one idle clock between.
   task automatic test_back_to_back();
      int n, idle_n, idle_at;
      n = 2 * (W + PB) + 1;
      idle_n = 0; idle_at = -1;
      din_b = 8'hFF; lv_b = 1'b1;
      @(posedge clk); #1;
      din_b = 8'h00;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (k == W + PB + 2) lv_b = 1'b0;
         if (sv_b !== 1'b1) begin idle_n++; idle_at = k; end
         if (k <= W) begin
            total++;
            if (so_b !== 1'b1) begin bad++; $display("FAIL b2b_first bit %0d got %b want 1", k, so_b); end
         end
         if (k > W + PB + 1 && k <= 2 * W + PB + 1) begin
            total++;
            if (so_b !== 1'b0) begin bad++; $display("FAIL b2b_second bit %0d got %b want 0", k, so_b); end
         end
      end
      total++;
      if (idle_n != 1 || idle_at != W + PB + 1) begin
         bad++;
         $display("FAIL b2b_idle count=%0d at=%0d want 1 at %0d", idle_n, idle_at, W + PB + 1);
      end
      idle_cycles(4);
   endtask

   // load_valid held high with data_in counting up from 0x10 every clock.
   task automatic test_hold_increment();
      rx_a = {};
      din_a = 8'h10; lv_a = 1'b1;
      for (int c = 0; c < 3 * PER_A; c++) begin
         @(posedge clk); #1;
         din_a = din_a + 8'd1;
      end
      lv_a = 1'b0;
      idle_cycles(PER_A + 2);
      total++;
      if (rx_a.size() != 3) begin
         bad++;
         $display("FAIL hold_accepts got %0d want 3", rx_a.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            logic [W-1:0] ew;
            ew = W'(8'h10 + i * PER_A);
            total++;
            if (rx_a[i] !== ew) begin bad++; $display("FAIL hold_word %0d got %h want %h", i, rx_a[i], ew); end
         end
      end
   endtask

   // Reset asserted in cycle 4 of a frame, then a clean frame afterwards.
   task automatic test_reset_mid_frame();
      int fd_before, rx_before;
      fd_before = fdc_a; rx_before = rx_a.size();
      din_a = 8'hA5; lv_a = 1'b1;
      @(posedge clk); #1 lv_a = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      total += 3;
      if (sv_a !== 1'b0 || so_a !== 1'b0) begin bad++; $display("FAIL midrst_line got so/sv=%b%b want 00", so_a, sv_a); end
      if (fd_a !== 1'b0) begin bad++; $display("FAIL midrst_frame_done got %b want 0", fd_a); end
      if (lr_a !== 1'b1 || busy_a !== 1'b0) begin bad++; $display("FAIL midrst_ready got rdy/busy=%b%b want 10", lr_a, busy_a); end
      @(posedge clk); #2 rst = 1'b0;
      idle_cycles(3);
      total++;
      if (fdc_a != fd_before || rx_a.size() != rx_before) begin
         bad++;
         $display("FAIL midrst_partial got fd=%0d words=%0d want fd=%0d words=%0d",
                  fdc_a, rx_a.size(), fd_before, rx_before);
      end
      din_a = 8'h3C; lv_a = 1'b1;
      @(posedge clk); #1 lv_a = 1'b0;
      idle_cycles(PER_A + 1);
      total++;
      if (rx_a.size() != rx_before + 1 || rx_a[rx_a.size()-1] !== 8'h3C) begin
         bad++;
         $display("FAIL midrst_next got words=%0d last=%h want words=%0d last=3c",
                  rx_a.size(), (rx_a.size() > 0) ? rx_a[rx_a.size()-1] : 8'h00, rx_before + 1);
      end
   endtask

   // Random valid and data on both instances; the scoreboard checks every clock.
   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         lv_a  = ($urandom_range(0, 3) != 0);
         lv_b  = ($urandom_range(0, 2) == 0);
         din_a = W'($urandom);
         din_b = W'($urandom);
      end
      idle_cycles(PER_A + PER_B);
   endtask

   initial begin
      test_reset();
      test_msb_frame();
      test_lsb_first();
      test_back_to_back();
      test_hold_increment();
      test_reset_mid_frame();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
